// File: rtl/spi_flash_responder.sv
// spi_flash_responder: byte-lane serial memory slave with read/write commands into a 32-bit word memory
module spi_flash_responder #(
  parameter int MEM_AW      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       p_clk,
  input  logic       p_reset_n,
  input  logic       s_clk,
  input  logic       s_css,
  input  logic [7:0] s_mosi,
  output logic [7:0] s_miso,
  output logic       busy,
  output logic       wr_done,
  output logic       cmd_err
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DISCARD} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] clk_sync, css_sync, vld;
  logic clk_q, css_q, armed;
  logic is_wr, fetch, rd_show;
  logic [1:0] cnt;
  logic [31:0] asm_q;
  logic [MEM_AW-1:0] idx;
  logic [31:0] mem [0:(1<<MEM_AW)-1];
  wire clk_s = clk_sync[SYNC_STAGES-1];
  wire css_s = css_sync[SYNC_STAGES-1];
  wire css_fall = armed & css_q & ~css_s;
  wire css_rise = ~css_q & css_s;
  wire byte_ev = clk_s & ~clk_q & ~(css_s & css_q);
  wire [31:0] shifted = {asm_q[23:0], s_mosi};
  wire we = state == DATA && is_wr && byte_ev && cnt == 2'd3;
  assign s_miso = rd_show ? asm_q[31:24] : 8'h00;
  // synchronize s_clk/s_css; arm only after a genuine deselect is seen following reset
  always_ff @(posedge p_clk or negedge p_reset_n)
    if (!p_reset_n) begin
      clk_sync <= '0;
      css_sync <= '1;
      vld      <= '0;
      clk_q    <= 1'b0;
      css_q    <= 1'b1;
      armed    <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], s_clk};
      css_sync <= {css_sync[SYNC_STAGES-2:0], s_css};
      vld      <= {vld[SYNC_STAGES-2:0], 1'b1};
      clk_q    <= clk_s;
      css_q    <= css_s;
      armed    <= armed | (vld[SYNC_STAGES-1] & css_s);
    end
  // word memory is not reset; a write lands one cycle after the 4th data byte event
  always_ff @(posedge p_clk)
    if (we) mem[idx] <= shifted;
  // transaction state machine: command, 3 address bytes, 4 data bytes, then discard
  always_ff @(posedge p_clk or negedge p_reset_n)
    if (!p_reset_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      wr_done <= 1'b0;
      cmd_err <= 1'b0;
      is_wr   <= 1'b0;
      fetch   <= 1'b0;
      rd_show <= 1'b0;
      cnt     <= 2'd0;
      asm_q   <= '0;
      idx     <= '0;
    end else begin
      wr_done <= we;
      cmd_err <= 1'b0;
      fetch   <= 1'b0;
      if (fetch) begin
        asm_q   <= mem[idx];
        rd_show <= 1'b1;
      end
      if (css_rise) begin
        state   <= IDLE;
        busy    <= 1'b0;
        rd_show <= 1'b0;
      end else
        case (state)
          IDLE:
            if (css_fall) begin
              state <= CMD;
              busy  <= 1'b1;
              asm_q <= '0;
            end
          CMD:
            if (byte_ev) begin
              if (s_mosi == 8'h01 || s_mosi == 8'h02) begin
                is_wr <= s_mosi[1];
                cnt   <= 2'd0;
                state <= ADDR;
              end else begin
                cmd_err <= 1'b1;
                state   <= DISCARD;
              end
            end
          ADDR:
            if (byte_ev) begin
              asm_q <= shifted;
              cnt   <= cnt == 2'd2 ? 2'd0 : cnt + 2'd1;
              if (cnt == 2'd2) begin
                idx   <= shifted[MEM_AW-1:0];
                fetch <= ~is_wr;
                state <= DATA;
              end
            end
          DATA:
            if (byte_ev) begin
              asm_q <= is_wr ? shifted : {asm_q[23:0], 8'h00};
              cnt   <= cnt + 2'd1;
              if (cnt == 2'd3) begin
                rd_show <= 1'b0;
                state   <= DISCARD;
              end
            end
          DISCARD: state <= DISCARD;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: table-driven transactions plus reset and deselect corner sequences
module tb_spi_flash_responder;
  localparam int SS = 2;
  logic p_clk = 0, p_reset_n = 0, s_clk = 0, s_css = 1;
  logic [7:0] s_mosi = 0, s_miso;
  logic busy, wr_done, cmd_err;
  int checks = 0, errors = 0, nwr = 0, nerr = 0;

  spi_flash_responder #(.MEM_AW(8), .SYNC_STAGES(SS)) dut (
    .p_clk(p_clk), .p_reset_n(p_reset_n), .s_clk(s_clk), .s_css(s_css),
    .s_mosi(s_mosi), .s_miso(s_miso), .busy(busy), .wr_done(wr_done), .cmd_err(cmd_err));

  always #5 p_clk = ~p_clk;

  always @(negedge p_clk) begin
    if (wr_done) nwr++;
    if (cmd_err) nerr++;
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [31:0] data;
    int          n;
    logic [31:0] rd;
    int          wr;
    int          err;
  } vec_t;
  vec_t v[13];

  task automatic tick(input int n);
    repeat (n) @(posedge p_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, output logic [7:0] m);
    s_mosi = b;
    tick(4);
    m = s_miso;
    s_clk = 1;
    tick(6);
    s_clk = 0;
    tick(4);
  endtask

  task automatic xact(input logic [7:0] cmd, input logic [23:0] addr, input logic [31:0] data,
                      input int n, output logic [31:0] rd, output logic [7:0] tail,
                      output logic bmid, output logic bend);
    logic [7:0] m;
    s_css = 0;
    tick(6);
    send(cmd, m);
    send(addr[23:16], m);
    send(addr[15:8], m);
    send(addr[7:0], m);
    rd = 0;
    for (int i = 0; i < n; i++) begin
      send(data[31-8*i -: 8], m);
      rd = {rd[23:0], m};
    end
    tail = s_miso;
    bmid = busy;
    s_css = 1;
    tick(SS + 1);
    bend = busy;
    tick(3);
  endtask

  task automatic read_chk(input string name, input logic [23:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic [7:0] tail;
    logic bm, be;
    xact(8'h01, addr, 32'h0, 4, rd, tail, bm, be);
    chk(name, rd, exp);
    chk({name, "_tail"}, {24'h0, tail}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0] tail, m;
    logic bm, be;
    int w0, e0;
    v[0]  = '{8'h02, 24'h000005, 32'hDEADBEEF, 4, 32'h0,        1, 0};
    v[1]  = '{8'h01, 24'h000005, 32'h0,        4, 32'hDEADBEEF, 0, 0};
    v[2]  = '{8'h02, 24'h000105, 32'h12345678, 4, 32'h0,        1, 0};
    v[3]  = '{8'h01, 24'h000005, 32'h0,        4, 32'h12345678, 0, 0};
    v[4]  = '{8'h02, 24'h0000FF, 32'hCAFEF00D, 4, 32'h0,        1, 0};
    v[5]  = '{8'h01, 24'hAB00FF, 32'h0,        4, 32'hCAFEF00D, 0, 0};
    v[6]  = '{8'h7F, 24'h000005, 32'hA5A5A5A5, 4, 32'h0,        0, 1};
    v[7]  = '{8'h01, 24'h000005, 32'h0,        4, 32'h12345678, 0, 0};
    v[8]  = '{8'h02, 24'h000005, 32'hDEADBE00, 3, 32'h0,        0, 0};
    v[9]  = '{8'h01, 24'h000005, 32'h0,        4, 32'h12345678, 0, 0};
    v[10] = '{8'h00, 24'h000005, 32'h11223344, 4, 32'h0,        0, 1};
    v[11] = '{8'h02, 24'h000010, 32'h11111111, 4, 32'h0,        1, 0};
    v[12] = '{8'h03, 24'h000010, 32'h55555555, 4, 32'h0,        0, 1};

    tick(3);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_miso", {24'h0, s_miso}, 32'h0);
    chk("rst_wr_done", {31'h0, wr_done}, 32'h0);
    chk("rst_cmd_err", {31'h0, cmd_err}, 32'h0);
    p_reset_n = 1;
    tick(5);

    for (int i = 0; i < 13; i++) begin
      w0 = nwr;
      e0 = nerr;
      xact(v[i].cmd, v[i].addr, v[i].data, v[i].n, rd, tail, bm, be);
      chk($sformatf("v%0d_rd", i), rd, v[i].rd);
      chk($sformatf("v%0d_tail", i), {24'h0, tail}, 32'h0);
      chk($sformatf("v%0d_busy_mid", i), {31'h0, bm}, 32'h1);
      chk($sformatf("v%0d_busy_end", i), {31'h0, be}, 32'h0);
      chk($sformatf("v%0d_wr_done", i), nwr - w0, v[i].wr);
      chk($sformatf("v%0d_cmd_err", i), nerr - e0, v[i].err);
    end

    w0 = nwr;
    s_css = 0;
    tick(6);
    send(8'h02, m); send(8'h00, m); send(8'h00, m); send(8'h10, m);
    send(8'hAA, m); send(8'hBB, m);
    p_reset_n = 0;
    #1;
    chk("rstmid_busy", {31'h0, busy}, 32'h0);
    chk("rstmid_miso", {24'h0, s_miso}, 32'h0);
    chk("rstmid_wr_done", {31'h0, wr_done}, 32'h0);
    s_css = 1;
    tick(3);
    p_reset_n = 1;
    tick(6);
    chk("rstmid_no_write", nwr - w0, 32'h0);
    read_chk("rstmid_mem", 24'h000010, 32'h11111111);
    w0 = nwr;
    xact(8'h02, 24'h000010, 32'h22222222, 4, rd, tail, bm, be);
    chk("post_rst_wr_done", nwr - w0, 32'h1);
    read_chk("post_rst_mem", 24'h000010, 32'h22222222);

    p_reset_n = 0;
    s_css = 0;
    tick(2);
    p_reset_n = 1;
    tick(6);
    w0 = nwr;
    send(8'h02, m); send(8'h00, m); send(8'h00, m); send(8'h10, m);
    for (int i = 0; i < 4; i++) send(8'h33, m);
    chk("held_sel_busy", {31'h0, busy}, 32'h0);
    chk("held_sel_wr_done", nwr - w0, 32'h0);
    s_css = 1;
    tick(6);
    read_chk("held_sel_mem", 24'h000010, 32'h22222222);

    w0 = nwr;
    s_css = 0;
    tick(6);
    send(8'h02, m); send(8'h00, m); send(8'h00, m); send(8'h20, m);
    send(8'h01, m); send(8'h02, m); send(8'h03, m);
    s_mosi = 8'h04;
    tick(4);
    s_clk = 1;
    s_css = 1;
    tick(6);
    s_clk = 0;
    tick(4);
    chk("race_wr_done", nwr - w0, 32'h1);
    chk("race_busy", {31'h0, busy}, 32'h0);
    read_chk("race_mem", 24'h000020, 32'h01020304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
